tictactoe_mover: RTL and testbench

- Move generator that drives the tic-tac-toe board's move input (the other end of the 4-bit move interface).
- On request, snapshots the current board and computes a legal move for the requested side. Priority order: immediate win, block opponent's win, centre, first empty cell.
- Each board cell is examined serially, one per cycle, through a small FSM.
- Presents the result on a valid/ack handshake, which sits in front of the board's move input.

---
 rtl/tictactoe_pkg.sv | 63 ++++++
 rtl/tictactoe_cell_eval.sv | 21 ++
 rtl/tictactoe_mover.sv | 146 ++++++++++++++
 tb/tb_tictactoe_mover.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared constants, line table, states and board helpers for the move generator
package tictactoe_pkg;

    localparam int CELL_COUNT = 9;
    localparam int LINE_COUNT = 8;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] X     = 2'd1;
    localparam logic [1:0] O     = 2'd2;

    localparam logic [3:0] NO_MOVE = 4'd15;

    // Entry l occupies bits [12l+11:12l] as {a, b, c}; entry 0 is the top row.
    localparam logic [95:0] LINES = {
        4'd2, 4'd4, 4'd6,
        4'd0, 4'd4, 4'd8,
        4'd2, 4'd5, 4'd8,
        4'd1, 4'd4, 4'd7,
        4'd0, 4'd3, 4'd6,
        4'd6, 4'd7, 4'd8,
        4'd3, 4'd4, 4'd5,
        4'd0, 4'd1, 4'd2
    };

    typedef enum logic [2:0] {
        IDLE,
        WIN,
        BLOCK,
        CENTER,
        FIRST,
        DONE
    } state_t;

    // Out-of-range indices read as a cell owned by neither player.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
        logic [1:0] c;
        c = 2'd3;
        if (i < 4'd9) c = b[{i, 1'b0} +: 2];
        return c;
    endfunction

    function automatic logic line_win(input logic [17:0] b, input logic [1:0] p);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < LINE_COUNT; l++) begin
            if (cell_at(b, LINES[l*12+8 +: 4]) == p &&
                cell_at(b, LINES[l*12+4 +: 4]) == p &&
                cell_at(b, LINES[l*12   +: 4]) == p)
                hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic board_full(input logic [17:0] b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < CELL_COUNT; i++) begin
            if (cell_at(b, 4'(i)) == EMPTY) full = 1'b0;
        end
        return full;
    endfunction

endpackage

// File: rtl/tictactoe_cell_eval.sv
// rtl/tictactoe_cell_eval.sv - tests one cell: empty, and whether placing player there completes a line
module tictactoe_cell_eval
    import tictactoe_pkg::*;
(
    input  logic [17:0] snap,
    input  logic [3:0]  idx,
    input  logic [1:0]  player,
    output logic        is_empty,
    output logic        wins
);

    logic [17:0] placed;

    always_comb begin
        placed   = snap;
        is_empty = (idx < 4'd9) && (cell_at(snap, idx) == EMPTY);
        if (is_empty) placed[{idx, 1'b0} +: 2] = player;
        wins     = is_empty && line_win(placed, player);
    end

endmodule

// File: rtl/tictactoe_mover.sv
// rtl/tictactoe_mover.sv - serial tic-tac-toe move generator with valid/ack result handshake
module tictactoe_mover
    import tictactoe_pkg::*;
#(
    parameter int CELLS = 9,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       side,
    input  logic [17:0]      board,
    input  logic             move_ack,
    output logic             move_valid,
    output logic [IDX_W-1:0] move,
    output logic             no_move,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] CENTER_IDX = IDX_W'(4);

    state_t           state, state_n;
    logic [17:0]      snap, snap_n;
    logic [1:0]       me, me_n;
    logic [1:0]       opp, opp_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [IDX_W-1:0] res, res_n;
    logic             nm, nm_n;

    logic [1:0]       eval_player;
    logic             eval_empty;
    logic             eval_wins;
    logic             side_bad;
    logic             board_over;

    assign eval_player = (state == BLOCK) ? opp : me;
    assign side_bad    = (side != X) && (side != O);
    assign board_over  = line_win(board, X) || line_win(board, O) || board_full(board);

    tictactoe_cell_eval u_cell_eval (
        .snap     (snap),
        .idx      (idx),
        .player   (eval_player),
        .is_empty (eval_empty),
        .wins     (eval_wins)
    );

    always_comb begin
        state_n = state;
        snap_n  = snap;
        me_n    = me;
        opp_n   = opp;
        idx_n   = idx;
        res_n   = res;
        nm_n    = nm;
        case (state)
            IDLE: begin
                if (req) begin
                    snap_n = board;
                    me_n   = side;
                    opp_n  = (side == X) ? O : X;
                    idx_n  = '0;
                    if (side_bad || board_over) begin
                        nm_n    = 1'b1;
                        res_n   = NO_MOVE;
                        state_n = DONE;
                    end else begin
                        nm_n    = 1'b0;
                        state_n = WIN;
                    end
                end
            end
            WIN, BLOCK: begin
                if (eval_wins) begin
                    res_n   = idx;
                    state_n = DONE;
                end else if (idx == LAST_IDX) begin
                    idx_n   = '0;
                    state_n = (state == WIN) ? BLOCK : CENTER;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            CENTER: begin
                if (cell_at(snap, CENTER_IDX) == EMPTY) begin
                    res_n   = CENTER_IDX;
                    state_n = DONE;
                end else begin
                    idx_n   = '0;
                    state_n = FIRST;
                end
            end
            FIRST: begin
                if (eval_empty) begin
                    res_n   = idx;
                    state_n = DONE;
                end else if (idx == LAST_IDX) begin
                    nm_n    = 1'b1;
                    res_n   = NO_MOVE;
                    state_n = DONE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            DONE: begin
                if (move_ack) begin
                    nm_n    = 1'b0;
                    res_n   = NO_MOVE;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so DONE shows on the entering edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snap       <= '0;
            me         <= '0;
            opp        <= '0;
            idx        <= '0;
            res        <= NO_MOVE;
            nm         <= 1'b0;
            move_valid <= 1'b0;
            move       <= NO_MOVE;
            no_move    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            snap       <= snap_n;
            me         <= me_n;
            opp        <= opp_n;
            idx        <= idx_n;
            res        <= res_n;
            nm         <= nm_n;
            move_valid <= (state_n == DONE);
            move       <= (state_n == DONE) ? res_n : NO_MOVE;
            no_move    <= (state_n == DONE) && nm_n;
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_tictactoe_mover.sv
// tb/tb_tictactoe_mover.sv - directed vector bench for tictactoe_mover
module tb_tictactoe_mover;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  side = 2'd0;
    logic [17:0] board = '0;
    logic        move_ack = 1'b0;
    logic        move_valid;
    logic [3:0]  move;
    logic        no_move;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e0      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tictactoe_mover dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .side       (side),
        .board      (board),
        .move_ack   (move_ack),
        .move_valid (move_valid),
        .move       (move),
        .no_move    (no_move),
        .busy       (busy)
    );

    typedef struct {
        string       name;
        logic [17:0] b;
        logic [1:0]  s;
        int          mv;
        int          nm;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [17:0] bd(input string s);
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            case (s[i])
                "X":     r[2*i +: 2] = 2'd1;
                "O":     r[2*i +: 2] = 2'd2;
                "3":     r[2*i +: 2] = 2'd3;
                default: r[2*i +: 2] = 2'd0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start(input logic [17:0] b, input logic [1:0] s);
        @(negedge clock);
        board = b;
        side  = s;
        req   = 1'b1;
        @(posedge clock);
        e0 = cyc + 1;
        #1;
        req = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        while (!move_valid && (cyc - e0) < 40) begin
            @(posedge clock);
            #1;
        end
        lat = move_valid ? (cyc - e0) : -1;
    endtask

    task automatic ack(input string nm);
        @(negedge clock);
        move_ack = 1'b1;
        @(posedge clock);
        #1;
        move_ack = 1'b0;
        chk({nm, " ack valid"}, move_valid, 0);
        chk({nm, " ack busy"}, busy, 0);
        chk({nm, " ack move"}, move, 15);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start(v.b, v.s);
        wait_valid(lat);
        chk({v.name, " latency"}, lat, v.lat);
        chk({v.name, " move"}, move, v.mv);
        chk({v.name, " no_move"}, no_move, v.nm);
        ack(v.name);
    endtask

    initial begin
        int lat;
        vecs.push_back('{"x win 2",      bd("XX.OO...."), 2'd1,  2, 0,  3});
        vecs.push_back('{"o win 5",      bd("XX.OO...."), 2'd2,  5, 0,  6});
        vecs.push_back('{"o block 2",    bd("XX..O...."), 2'd2,  2, 0, 12});
        vecs.push_back('{"tie board",    bd("XOXXOOOXX"), 2'd1, 15, 1,  0});
        vecs.push_back('{"side 0",       bd("........."), 2'd0, 15, 1,  0});
        vecs.push_back('{"side 3",       bd("........."), 2'd3, 15, 1,  0});
        vecs.push_back('{"x already won",bd("XXXOO...."), 2'd2, 15, 1,  0});
        vecs.push_back('{"first 1",      bd("O...X...."), 2'd2,  1, 0, 21});
        vecs.push_back('{"block 0",      bd("...X..X.."), 2'd2,  0, 0, 10});
        vecs.push_back('{"win 0",        bd("...X..X.."), 2'd1,  0, 0,  1});
        vecs.push_back('{"win 8",        bd("X...X...."), 2'd1,  8, 0,  9});
        vecs.push_back('{"first 0",      bd("....X...."), 2'd2,  0, 0, 20});
        vecs.push_back('{"code3 first 3",bd("3XX.O.O.."), 2'd1,  3, 0, 23});

        #12;
        chk("reset valid", move_valid, 0);
        chk("reset move", move, 15);
        chk("reset no_move", no_move, 0);
        chk("reset busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // Empty board: centre at E19; stray req and board change mid-scan are ignored.
        start(bd("........."), 2'd1);
        chk("busy after E0", busy, 1);
        repeat (4) @(posedge clock);
        #2;
        board = bd("XX.XX....");
        side  = 2'd2;
        req   = 1'b1;
        @(posedge clock);
        #1;
        req = 1'b0;
        wait_valid(lat);
        chk("centre latency", lat, 19);
        chk("centre move", move, 4);
        chk("centre no_move", no_move, 0);
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("hold valid", move_valid, 1);
            chk("hold move", move, 4);
        end
        ack("centre");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Board input rewritten during the scan has no effect.
        start(bd("O...X...."), 2'd2);
        repeat (5) @(posedge clock);
        #2;
        board = bd("XXXXXXXX.");
        wait_valid(lat);
        chk("board change latency", lat, 21);
        chk("board change move", move, 1);
        ack("board change");

        // Async reset in the BLOCK phase, then a normal request.
        start(bd("........."), 2'd1);
        repeat (12) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset valid", move_valid, 0);
        chk("mid reset no_move", no_move, 0);
        chk("mid reset move", move, 15);
        @(negedge clock);
        reset = 1'b0;
        run_vec(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
